prefetch_unit: RTL and testbench
================================

// Module: prefetch_unit
// PURPOSE
//  Parametrised instruction fetch front end: owns the program counter, fetches
//  INSTR_WIDTH-bit instructions as BPI bytes over a req/ack memory port, assembles
//  them low byte first and buffers them in a DEPTH-entry queue ahead of the decoder.
//  Sits between the memory arbiter and the control unit, replacing the PC plus
//  byte-written instruction register with a stall-tolerant, flushable pipeline stage.
// PARAMETERS
//  ADDR_WIDTH   15  byte address / PC width; PC arithmetic wraps mod 2^ADDR_WIDTH
//  DATA_WIDTH   8   memory byte width
//  INSTR_WIDTH  16  instruction width; must be an integer multiple of DATA_WIDTH
//  DEPTH        4   queue entries, power of two, >= 2
//  RESET_PC     0   PC value after reset
// PORTS
//  clk          in   1            clock, all state on rising edge
//  reset        in   1            asynchronous, active-low reset
//  busGrant     in   1            1 = memory port free for fetch this cycle
//  memReq       out  1            fetch request; held until memAck
//  memAddr      out  ADDR_WIDTH   byte address; stable while memReq=1
//  memAck       in   1            request accepted, memReadBus valid this cycle
//  memReadBus   in   DATA_WIDTH   read data
//  redirectEn   in   1            flush queue and restart fetch at redirectPc
//  redirectPc   in   ADDR_WIDTH   new fetch address
//  instrReady   in   1            consumer pops head when instrValid=1
//  instrValid   out  1            queue head valid
//  instrOut     out  INSTR_WIDTH  queue head instruction
//  instrPc      out  ADDR_WIDTH   address of first byte of queue head
//  misalignFault out 1            only with MISALIGN_TRAP_EN (tied 0 otherwise)
// BEHAVIOUR
//  - BPI = INSTR_WIDTH/DATA_WIDTH. Reset: memReq=0, memAddr=RESET_PC, instrValid=0,
//    instrOut=0, instrPc=0, misalignFault=0, fetchPc=RESET_PC, byteIdx=0, queue empty.
//  - FSM IDLE/REQ/(FAULT). IDLE->REQ when busGrant=1 and free slots (DEPTH - count -
//    in-assembly) > 0. In REQ memReq=1, memAddr=fetchPc+byteIdx (wraps); busGrant is
//    ignored once memReq is high. memAck: byte captured into lane byteIdx; byteIdx++.
//  - Last byte acked: entry {assembled, fetchPc} pushed on that edge; instrValid high
//    next cycle; fetchPc += BPI; byteIdx=0. Zero-wait memory (ack in request cycle)
//    with continuous grant sustains one byte per cycle, REQ held across bytes.
//  - busGrant low between bytes: partial assembly kept, resumes at same byteIdx.
//  - Pop when instrValid & instrReady; push and pop in same cycle allowed, count unchanged.
//  - Full: no new request raised; a request already in flight cannot exist (slot reserved).
//  - redirectEn: queue emptied, byteIdx=0, fetchPc=redirectPc, same-cycle pop ignored.
//    If memReq=1 and memAck not yet seen, request stays asserted to completion and its
//    data is discarded; refetch starts the cycle after. Redirect coincident with ack:
//    data discarded, new address next request.
//  - Async reset mid-request drops memReq immediately; memory side must tolerate it.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: redirectPc not a multiple of BPI -> FAULT state,
//    misalignFault=1 (sticky), no fetch, instrValid=0 until next aligned redirect.
//  Undefined: redirectPc low log2(BPI) bits forced to 0; no FAULT state.
// STRUCTURE
//  - Shared fetch defs header: FSM state encoding, BPI and log2(BPI) localparams.
//  - Sub-module instr_queue: DEPTH x (INSTR_WIDTH+ADDR_WIDTH) FIFO, flush input,
//    count output; FSM, PC and byte assembly stay in prefetch_unit.
// TESTING
//  1. Reset, grant=1, zero-wait mem bytes 0x34,0x12 at 0,1 -> memAddr 0,1; instrOut
//     0x1234, instrPc 0 valid on cycle 3; next fetch at addr 2.
//  2. instrReady=0, grant=1 -> exactly DEPTH=4 entries fetched (8 acks), memReq then
//     stays 0; one pop -> next request within 1 cycle.
//  3. Ack delayed 3 cycles, grant dropped mid-wait -> memReq/memAddr stable until ack;
//     grant low after byte 0 -> byte 1 request waits, assembly intact.
//  4. redirectEn to 0x0100 while request to 0x0006 outstanding -> queue empty,
//     0x0006 data discarded, next memAddr 0x0100, instrPc 0x0100.
//  5. Redirect to 0x7FFE -> fetches 0x7FFE,0x7FFF then wraps to 0x0000.
//  6. Redirect to 0x0101: with MISALIGN_TRAP_EN misalignFault=1, memReq=0 until
//     redirect 0x0200; without it fetch starts at 0x0100.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared fetch definitions: FSM state encoding, default geometry and byte-lane index width helper.
// Build option MISALIGN_TRAP_EN adds the FAULT state to the encoding.
package prefetch_unit_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 15;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_INSTR_WIDTH = 16;
    localparam int DEFAULT_DEPTH       = 4;

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } fetchState_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1
    } fetchState_t;
`endif

    // Width of the byte-lane index; a one-byte instruction still gets a 1-bit index.
    function automatic int idxWidth(input int bytesPerInstr);
        return (bytesPerInstr > 1) ? $clog2(bytesPerInstr) : 1;
    endfunction

endpackage

// File: rtl/prefetch_unit_if.sv
// Fetch front-end bus bundle: memory req/ack port, redirect request and decoder-facing instruction port.
interface prefetch_unit_if #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   busGrant;
    logic                   memReq;
    logic [ADDR_WIDTH-1:0]  memAddr;
    logic                   memAck;
    logic [DATA_WIDTH-1:0]  memReadBus;
    logic                   redirectEn;
    logic [ADDR_WIDTH-1:0]  redirectPc;
    logic                   instrReady;
    logic                   instrValid;
    logic [INSTR_WIDTH-1:0] instrOut;
    logic [ADDR_WIDTH-1:0]  instrPc;
    logic                   misalignFault;

    modport master (
        input  busGrant, memAck, memReadBus, redirectEn, redirectPc, instrReady,
        output memReq, memAddr, instrValid, instrOut, instrPc, misalignFault
    );

    modport slave (
        output busGrant, memAck, memReadBus, redirectEn, redirectPc, instrReady,
        input  memReq, memAddr, instrValid, instrOut, instrPc, misalignFault
    );
endinterface

// File: rtl/prefetch_unit_instr_queue.sv
// Flushable FIFO holding assembled {instruction, pc} entries ahead of the decoder.
module prefetch_unit_instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 31,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             notEmpty,
    output logic [CNTW-1:0]  count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;

    // Flush wins over a coincident push or pop so a redirect always leaves the queue empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[wrPtr] <= pushData;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign headData = entries[rdPtr];
    assign notEmpty = (count != '0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction fetch front end: owns the PC, assembles BPI bytes low-first and queues them for the decoder.
// Build option MISALIGN_TRAP_EN: misaligned redirects enter a sticky FAULT state instead of aligning down.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    prefetch_unit_if.master bus
);
    localparam int BPI  = INSTR_WIDTH / DATA_WIDTH;
    localparam int IDXW = idxWidth(BPI);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [IDXW-1:0]       LAST_IDX   = IDXW'(BPI - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BPI - 1));

    fetchState_t             state, nextState;
    logic [ADDR_WIDTH-1:0]   fetchPc, discardAddr, redirectTarget, reqAddr;
    logic [IDXW-1:0]         byteIdx;
    logic [INSTR_WIDTH-1:0]  assembly, assembledNext;
    logic [CNTW-1:0]         count;
    logic [INSTR_WIDTH+ADDR_WIDTH-1:0] headEntry;
    logic discard, reqActive, byteAck, push, pop, queueValid, canStart, lastByte;

`ifdef MISALIGN_TRAP_EN
    logic redirectAligned;
    assign redirectAligned = ((bus.redirectPc & ~ALIGN_MASK) == '0);
    assign redirectTarget  = bus.redirectPc;
`else
    assign redirectTarget  = bus.redirectPc & ALIGN_MASK;
`endif

    assign lastByte  = (byteIdx == LAST_IDX);
    assign byteAck   = (state == REQ) && !discard && bus.memAck && !bus.redirectEn;
    assign push      = byteAck && lastByte;
    assign pop       = queueValid && bus.instrReady && !bus.redirectEn;
    // A partially assembled instruction already owns its slot, so it may always resume.
    assign canStart  = (byteIdx != '0) || (count < CNTW'(DEPTH));
    assign reqActive = (state == REQ) || discard;
    assign reqAddr   = discard ? discardAddr : fetchPc + ADDR_WIDTH'(byteIdx);

    always_comb begin
        assembledNext = assembly;
        assembledNext[int'(byteIdx)*DATA_WIDTH +: DATA_WIDTH] = bus.memReadBus;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.busGrant && canStart && (!discard || bus.memAck)) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                if (bus.memAck) begin
                    if (!bus.busGrant) begin
                        nextState = IDLE;
                    end else if (lastByte && (int'(count) + 1 >= DEPTH)) begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = state;
        endcase
        if (bus.redirectEn) begin
`ifdef MISALIGN_TRAP_EN
            nextState = redirectAligned ? IDLE : FAULT;
`else
            nextState = IDLE;
`endif
        end
    end

    // A redirect during an unacknowledged request keeps the old address driven until its ack is swallowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetchPc     <= RESET_PC;
            byteIdx     <= '0;
            assembly    <= '0;
            discard     <= 1'b0;
            discardAddr <= '0;
        end else begin
            state <= nextState;
            if (bus.redirectEn) begin
                fetchPc <= redirectTarget;
                byteIdx <= '0;
                if (reqActive && !bus.memAck) begin
                    discard <= 1'b1;
                    if (!discard) begin
                        discardAddr <= reqAddr;
                    end
                end else begin
                    discard <= 1'b0;
                end
            end else begin
                if (discard && bus.memAck) begin
                    discard <= 1'b0;
                end
                if (byteAck) begin
                    assembly <= assembledNext;
                    if (lastByte) begin
                        byteIdx <= '0;
                        fetchPc <= fetchPc + ADDR_WIDTH'(BPI);
                    end else begin
                        byteIdx <= byteIdx + 1'b1;
                    end
                end
            end
        end
    end

    prefetch_unit_instr_queue #(
        .DEPTH(DEPTH),
        .WIDTH(INSTR_WIDTH + ADDR_WIDTH),
        .CNTW (CNTW)
    ) instrQueue (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.redirectEn),
        .push    (push),
        .pushData({assembledNext, fetchPc}),
        .pop     (pop),
        .headData(headEntry),
        .notEmpty(queueValid),
        .count   (count)
    );

    assign bus.memReq     = reqActive;
    assign bus.memAddr    = reqAddr;
    assign bus.instrValid = queueValid;
    assign bus.instrOut   = headEntry[INSTR_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign bus.instrPc    = headEntry[ADDR_WIDTH-1:0];
`ifdef MISALIGN_TRAP_EN
    assign bus.misalignFault = (state == FAULT);
`else
    assign bus.misalignFault = 1'b0;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus a randomized stream against a PC-sequence model.
module tb_prefetch_unit;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int IW = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int ackDelay = 0;
    int waitCnt = 0;
    logic [AW-1:0] ackLog[$];
    logic [7:0] memImage [0:(1<<AW)-1];

    always #5 clk = ~clk;

    prefetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_WIDTH(IW)) bus();

    prefetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Memory model: acknowledges ackDelay cycles after the request (0 = same cycle), data from memImage.
    initial begin
        bus.memAck = 1'b0;
        bus.memReadBus = '0;
        forever begin
            @(negedge clk);
            if (bus.memReq === 1'b1) begin
                if (waitCnt >= ackDelay) begin
                    bus.memAck = 1'b1;
                    bus.memReadBus = memImage[bus.memAddr];
                    ackLog.push_back(bus.memAddr);
                    waitCnt = 0;
                end else begin
                    bus.memAck = 1'b0;
                    waitCnt++;
                end
            end else begin
                bus.memAck = 1'b0;
                waitCnt = 0;
            end
        end
    end

    // Reference: an instruction at pc is the two bytes at pc and pc+1 (wrapping), low byte first.
    function automatic logic [IW-1:0] expInstr(input logic [AW-1:0] pc);
        logic [AW-1:0] nxt;
        nxt = pc + 1'b1;
        return {memImage[nxt], memImage[pc]};
    endfunction

    task automatic applyReset();
        bus.busGrant = 1'b0; bus.redirectEn = 1'b0; bus.redirectPc = '0; bus.instrReady = 1'b0;
        ackDelay = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic doRedirect(input logic [AW-1:0] pc);
        bus.redirectEn = 1'b1; bus.redirectPc = pc;
        @(posedge clk); #1;
        bus.redirectEn = 1'b0;
    endtask

    task automatic waitValid(input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.instrValid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.busGrant = 1'b0; bus.redirectEn = 1'b0; bus.redirectPc = '0; bus.instrReady = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_memReq: got %b expected 0", bus.memReq); end
        checks++; if (bus.memAddr !== 15'h0) begin errors++; $display("[TB] FAIL reset_memAddr: got %h expected 0", bus.memAddr); end
        checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instrValid: got %b expected 0", bus.instrValid); end
        checks++; if (bus.instrOut !== 16'h0) begin errors++; $display("[TB] FAIL reset_instrOut: got %h expected 0", bus.instrOut); end
        checks++; if (bus.instrPc !== 15'h0) begin errors++; $display("[TB] FAIL reset_instrPc: got %h expected 0", bus.instrPc); end
        checks++; if (bus.misalignFault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", bus.misalignFault); end
        reset = 1'b1;
    endtask

    task automatic test_zero_wait();
        applyReset();
        memImage[0] = 8'h34; memImage[1] = 8'h12;
        bus.busGrant = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 15'h0) begin errors++; $display("[TB] FAIL zw_req0: got req=%b addr=%h expected req=1 addr=0", bus.memReq, bus.memAddr); end
        @(posedge clk); #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 15'h1) begin errors++; $display("[TB] FAIL zw_req1: got req=%b addr=%h expected req=1 addr=1", bus.memReq, bus.memAddr); end
        checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("[TB] FAIL zw_early_valid: got %b expected 0", bus.instrValid); end
        @(posedge clk); #1;
        checks++; if (bus.instrValid !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid: got %b expected 1", bus.instrValid); end
        checks++; if (bus.instrOut !== 16'h1234) begin errors++; $display("[TB] FAIL zw_instrOut: got %h expected 1234", bus.instrOut); end
        checks++; if (bus.instrPc !== 15'h0) begin errors++; $display("[TB] FAIL zw_instrPc: got %h expected 0", bus.instrPc); end
        checks++; if (bus.memAddr !== 15'h2) begin errors++; $display("[TB] FAIL zw_nextAddr: got %h expected 2", bus.memAddr); end
    endtask

    task automatic test_full();
        applyReset();
        ackLog.delete();
        bus.busGrant = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (ackLog.size() != 2 * DEPTH) begin errors++; $display("[TB] FAIL full_ackCount: got %0d expected %0d", ackLog.size(), 2 * DEPTH); end
        for (int i = 0; i < ackLog.size(); i++) begin
            checks++; if (ackLog[i] !== AW'(i)) begin errors++; $display("[TB] FAIL full_ackAddr%0d: got %h expected %h", i, ackLog[i], AW'(i)); end
        end
        checks++; if (bus.memReq !== 1'b0) begin errors++; $display("[TB] FAIL full_reqIdle: got %b expected 0", bus.memReq); end
        checks++; if (bus.instrPc !== 15'h0 || bus.instrOut !== expInstr(0)) begin errors++; $display("[TB] FAIL full_head: got pc=%h instr=%h expected pc=0 instr=%h", bus.instrPc, bus.instrOut, expInstr(0)); end
        bus.instrReady = 1'b1;
        @(posedge clk); #1;
        bus.instrReady = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 15'h8) begin errors++; $display("[TB] FAIL full_refill: got req=%b addr=%h expected req=1 addr=8", bus.memReq, bus.memAddr); end
    endtask

    task automatic test_delayed_ack();
        applyReset();
        ackLog.delete();
        ackDelay = 3;
        bus.busGrant = 1'b1;
        @(posedge clk); #1;
        bus.busGrant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 15'h0) begin errors++; $display("[TB] FAIL dly_hold%0d: got req=%b addr=%h expected req=1 addr=0", k, bus.memReq, bus.memAddr); end
            if (k < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++; if (ackLog.size() != 1) begin errors++; $display("[TB] FAIL dly_ackCount: got %0d expected 1", ackLog.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.memReq !== 1'b0) begin errors++; $display("[TB] FAIL dly_paused%0d: got req=%b expected 0", k, bus.memReq); end
            @(posedge clk); #1;
        end
        ackDelay = 0;
        bus.busGrant = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 15'h1) begin errors++; $display("[TB] FAIL dly_resume: got req=%b addr=%h expected req=1 addr=1", bus.memReq, bus.memAddr); end
        bus.busGrant = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.instrValid !== 1'b1 || bus.instrOut !== expInstr(0) || bus.instrPc !== 15'h0) begin errors++; $display("[TB] FAIL dly_entry: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=0", bus.instrValid, bus.instrOut, bus.instrPc, expInstr(0)); end
    endtask

    task automatic test_redirect_outstanding();
        bit found;
        bit seen;
        applyReset();
        ackDelay = 5;
        bus.busGrant = 1'b1; bus.instrReady = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.memReq === 1'b1 && bus.memAddr === 15'h6) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL redir_reach6: got no request to 0006 expected one within 100 cycles"); end
        ackLog.delete();
        bus.instrReady = 1'b0;
        doRedirect(15'h0100);
        checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got v=%b expected 0", bus.instrValid); end
        checks++; if (bus.memReq !== 1'b1 || bus.memAddr !== 15'h6) begin errors++; $display("[TB] FAIL redir_hold: got req=%b addr=%h expected req=1 addr=0006", bus.memReq, bus.memAddr); end
        waitValid(60, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL redir_timeout: got no valid entry expected one within 60 cycles"); end
        checks++; if (bus.instrPc !== 15'h0100 || bus.instrOut !== expInstr(15'h0100)) begin errors++; $display("[TB] FAIL redir_entry: got pc=%h instr=%h expected pc=0100 instr=%h", bus.instrPc, bus.instrOut, expInstr(15'h0100)); end
        checks++; if (ackLog.size() < 2) begin errors++; $display("[TB] FAIL redir_ackCount: got %0d expected at least 2", ackLog.size()); end
        else begin
            checks++; if (ackLog[0] !== 15'h6 || ackLog[1] !== 15'h0100) begin errors++; $display("[TB] FAIL redir_order: got %h,%h expected 0006,0100", ackLog[0], ackLog[1]); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] pc;
        applyReset();
        doRedirect(15'h7FFE);
        ackLog.delete();
        bus.busGrant = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        checks++; if (ackLog.size() < 4) begin errors++; $display("[TB] FAIL wrap_ackCount: got %0d expected at least 4", ackLog.size()); end
        else begin
            checks++; if (ackLog[0] !== 15'h7FFE || ackLog[1] !== 15'h7FFF || ackLog[2] !== 15'h0 || ackLog[3] !== 15'h1) begin
                errors++; $display("[TB] FAIL wrap_addrs: got %h,%h,%h,%h expected 7ffe,7fff,0000,0001", ackLog[0], ackLog[1], ackLog[2], ackLog[3]);
            end
        end
        pc = 15'h7FFE;
        bus.instrReady = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (bus.instrValid !== 1'b1 || bus.instrPc !== pc || bus.instrOut !== expInstr(pc)) begin
                errors++; $display("[TB] FAIL wrap_pop%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", k, bus.instrValid, bus.instrPc, bus.instrOut, pc, expInstr(pc));
            end
            pc = pc + 15'd2;
            @(posedge clk); #1;
        end
        bus.instrReady = 1'b0;
    endtask

    task automatic test_misalign();
        bit seen;
        applyReset();
        doRedirect(15'h0101);
        bus.busGrant = 1'b1;
`ifdef MISALIGN_TRAP_EN
        checks++; if (bus.misalignFault !== 1'b1) begin errors++; $display("[TB] FAIL mis_fault: got %b expected 1", bus.misalignFault); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (bus.memReq !== 1'b0 || bus.instrValid !== 1'b0 || bus.misalignFault !== 1'b1) begin
                errors++; $display("[TB] FAIL mis_stall%0d: got req=%b v=%b fault=%b expected 0,0,1", k, bus.memReq, bus.instrValid, bus.misalignFault);
            end
        end
        doRedirect(15'h0200);
        checks++; if (bus.misalignFault !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %b expected 0", bus.misalignFault); end
        waitValid(20, seen);
        checks++; if (!seen || bus.instrPc !== 15'h0200 || bus.instrOut !== expInstr(15'h0200)) begin
            errors++; $display("[TB] FAIL mis_restart: got v=%b pc=%h instr=%h expected v=1 pc=0200 instr=%h", seen, bus.instrPc, bus.instrOut, expInstr(15'h0200));
        end
`else
        checks++; if (bus.misalignFault !== 1'b0) begin errors++; $display("[TB] FAIL mis_noFault: got %b expected 0", bus.misalignFault); end
        waitValid(20, seen);
        checks++; if (!seen || bus.instrPc !== 15'h0100 || bus.instrOut !== expInstr(15'h0100)) begin
            errors++; $display("[TB] FAIL mis_align: got v=%b pc=%h instr=%h expected v=1 pc=0100 instr=%h", seen, bus.instrPc, bus.instrOut, expInstr(15'h0100));
        end
`endif
    endtask

    task automatic test_async_reset();
        applyReset();
        ackDelay = 4;
        bus.busGrant = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.memReq !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre: got req=%b expected 1", bus.memReq); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.memReq !== 1'b0 || bus.memAddr !== 15'h0) begin errors++; $display("[TB] FAIL arst_drop: got req=%b addr=%h expected req=0 addr=0", bus.memReq, bus.memAddr); end
        @(posedge clk); #1;
        reset = 1'b1;
        ackDelay = 0;
    endtask

    task automatic test_random_stream();
        logic [AW-1:0] expPc;
        logic [AW-1:0] tgt;
        bit newReady;
        bit doRedir;
        int pops;
        applyReset();
        expPc = '0;
        pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.busGrant = ($urandom_range(0, 3) != 0);
            ackDelay = $urandom_range(0, 2);
            newReady = 1'($urandom_range(0, 1));
            doRedir = ($urandom_range(0, 39) == 0);
            tgt = AW'($urandom);
`ifdef MISALIGN_TRAP_EN
            tgt[0] = 1'b0;
`endif
            bus.instrReady = newReady;
            bus.redirectEn = doRedir;
            bus.redirectPc = tgt;
            if (!doRedir && bus.instrValid === 1'b1 && newReady) begin
                checks++; if (bus.instrPc !== expPc || bus.instrOut !== expInstr(expPc)) begin
                    errors++; $display("[TB] FAIL rand_pop%0d: got pc=%h instr=%h expected pc=%h instr=%h", pops, bus.instrPc, bus.instrOut, expPc, expInstr(expPc));
                end
                pops++;
                expPc = expPc + 15'd2;
            end
            if (doRedir) expPc = {tgt[AW-1:1], 1'b0};
            @(posedge clk); #1;
        end
        bus.redirectEn = 1'b0;
        bus.instrReady = 1'b0;
        checks++; if (pops < 100) begin errors++; $display("[TB] FAIL rand_progress: got %0d pops expected at least 100", pops); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) memImage[i] = 8'($urandom);
        test_reset();
        test_zero_wait();
        test_full();
        test_delayed_ack();
        test_redirect_outstanding();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
